// File: rtl/clock_mode_controller.sv
// Mode sequencer for the digital clock: mode FSM, edit-field selection,
// SET-mode inactivity timeout and alarm triggering, with registered outputs.
module clock_mode_controller #(
   parameter int TIMEOUT_S = 30,
   parameter int RING_S    = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] btn,
   input  logic       tick_1hz,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   input  logic [4:0] alarm_hour,
   input  logic [5:0] alarm_min,
   input  logic       alarm_en,
   output logic [2:0] mode,
   output logic       fmt12,
   output logic [1:0] field,
   output logic       inc,
   output logic       dec,
   output logic       commit,
   output logic       sw_run,
   output logic       sw_clear,
   output logic       ring,
   output logic [5:0] led
);

   typedef enum logic [2:0] {
      DISP      = 3'd0,
      TIME_SET  = 3'd1,
      ALARM_SET = 3'd2,
      STOPWATCH = 3'd3,
      ALARMING  = 3'd4
   } mode_t;

   localparam int TO_W   = $clog2(TIMEOUT_S + 1);
   localparam int RING_W = $clog2(RING_S + 1);

   mode_t             mode_q, mode_nxt;
   mode_t             ret_q, ret_nxt;
   logic              fmt12_q, fmt12_nxt;
   logic [1:0]        field_q, field_nxt;
   logic              sw_run_q, sw_run_nxt;
   logic              ring_q, ring_nxt;
   logic              inc_nxt, dec_nxt, commit_nxt, sw_clear_nxt;
   logic [TO_W-1:0]   to_cnt, to_nxt;
   logic [RING_W-1:0] ring_cnt, ring_cnt_nxt;
   logic              match, match_d, trig;
   logic              alarm_en_d, alarm_fall;
   logic              b_mode, b_ok, b_sel, b_up, b_dn, any_btn;
   logic              dismiss;

   // Button priority: MODE > OK > SEL > UP > DOWN; only the winner is acted on.
   always_comb begin
      b_mode  = btn[0];
      b_ok    = btn[4] & ~btn[0];
      b_sel   = btn[1] & ~btn[4] & ~btn[0];
      b_up    = btn[2] & ~btn[1] & ~btn[4] & ~btn[0];
      b_dn    = btn[3] & ~btn[2] & ~btn[1] & ~btn[4] & ~btn[0];
      any_btn = |btn;
   end

   always_comb begin
      match      = alarm_en && (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
      trig       = match & ~match_d;
      alarm_fall = alarm_en_d & ~alarm_en;
   end

   always_comb begin
      mode_nxt     = mode_q;
      ret_nxt      = ret_q;
      fmt12_nxt    = fmt12_q;
      field_nxt    = field_q;
      sw_run_nxt   = sw_run_q;
      ring_nxt     = ring_q;
      to_nxt       = to_cnt;
      ring_cnt_nxt = ring_cnt;
      inc_nxt      = 1'b0;
      dec_nxt      = 1'b0;
      commit_nxt   = 1'b0;
      sw_clear_nxt = 1'b0;
      dismiss      = 1'b0;

      // A fresh alarm match outranks any button in the modes that honour it.
      if (trig && (mode_q == DISP || mode_q == STOPWATCH)) begin
         mode_nxt     = ALARMING;
         ret_nxt      = mode_q;
         ring_nxt     = 1'b1;
         ring_cnt_nxt = '0;
      end else begin
         case (mode_q)
            DISP: begin
               if (b_mode) begin
                  mode_nxt  = TIME_SET;
                  field_nxt = 2'd0;
                  to_nxt    = '0;
               end else if (b_sel) begin
                  fmt12_nxt = ~fmt12_q;
               end
            end

            TIME_SET, ALARM_SET: begin
               if (any_btn) begin
                  to_nxt = '0;
               end else if (tick_1hz) begin
                  to_nxt = to_cnt + TO_W'(1);
               end

               if (b_mode) begin
                  mode_nxt  = (mode_q == TIME_SET) ? ALARM_SET : STOPWATCH;
                  field_nxt = 2'd0;
                  to_nxt    = '0;
               end else if (b_ok) begin
                  commit_nxt = 1'b1;
                  mode_nxt   = DISP;
                  field_nxt  = 2'd0;
                  to_nxt     = '0;
               end else if (b_sel) begin
                  if (mode_q == TIME_SET) begin
                     field_nxt = (field_q >= 2'd2) ? 2'd0 : field_q + 2'd1;
                  end else begin
                     field_nxt = (field_q == 2'd0) ? 2'd1 : 2'd0;
                  end
               end else if (b_up) begin
                  inc_nxt = 1'b1;
               end else if (b_dn) begin
                  dec_nxt = 1'b1;
               end else if (!any_btn && tick_1hz && (to_cnt == TO_W'(TIMEOUT_S - 1))) begin
                  // Abandon the edit silently: no commit.
                  mode_nxt  = DISP;
                  field_nxt = 2'd0;
                  to_nxt    = '0;
               end
            end

            STOPWATCH: begin
               if (b_mode) begin
                  mode_nxt = DISP;
               end else if (b_up) begin
                  sw_run_nxt = ~sw_run_q;
               end else if (b_dn && !sw_run_q) begin
                  sw_clear_nxt = 1'b1;
               end
            end

            ALARMING: begin
               if (any_btn || alarm_fall) begin
                  dismiss = 1'b1;
               end else if (tick_1hz) begin
                  if (ring_cnt == RING_W'(RING_S - 1)) begin
                     dismiss = 1'b1;
                  end else begin
                     ring_cnt_nxt = ring_cnt + RING_W'(1);
                  end
               end
               if (dismiss) begin
                  ring_nxt     = 1'b0;
                  mode_nxt     = ret_q;
                  ring_cnt_nxt = '0;
               end
            end

            default: begin
               mode_nxt  = DISP;
               field_nxt = 2'd0;
               ring_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= DISP;
         ret_q      <= DISP;
         fmt12_q    <= 1'b0;
         field_q    <= 2'd0;
         sw_run_q   <= 1'b0;
         ring_q     <= 1'b0;
         to_cnt     <= '0;
         ring_cnt   <= '0;
         inc        <= 1'b0;
         dec        <= 1'b0;
         commit     <= 1'b0;
         sw_clear   <= 1'b0;
         match_d    <= 1'b1;
         alarm_en_d <= 1'b0;
         led        <= 6'b000001;
      end else begin
         mode_q     <= mode_nxt;
         ret_q      <= ret_nxt;
         fmt12_q    <= fmt12_nxt;
         field_q    <= field_nxt;
         sw_run_q   <= sw_run_nxt;
         ring_q     <= ring_nxt;
         to_cnt     <= to_nxt;
         ring_cnt   <= ring_cnt_nxt;
         inc        <= inc_nxt;
         dec        <= dec_nxt;
         commit     <= commit_nxt;
         sw_clear   <= sw_clear_nxt;
         match_d    <= match;
         alarm_en_d <= alarm_en;
         led        <= {alarm_en, 5'b00001 << mode_nxt};
      end
   end

   always_comb begin
      mode   = mode_q;
      fmt12  = fmt12_q;
      field  = field_q;
      sw_run = sw_run_q;
      ring   = ring_q;
   end

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller: hand-computed expectations
// checked with immediate assertions after each step.
module tb_clock_mode_controller;

   localparam logic [5:0] B_MODE = 6'b000001;
   localparam logic [5:0] B_SEL  = 6'b000010;
   localparam logic [5:0] B_UP   = 6'b000100;
   localparam logic [5:0] B_DN   = 6'b001000;
   localparam logic [5:0] B_OK   = 6'b010000;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] btn;
   logic       tick_1hz;
   logic [4:0] cur_hour, alarm_hour;
   logic [5:0] cur_min, cur_sec, alarm_min;
   logic       alarm_en;
   logic [2:0] mode;
   logic       fmt12;
   logic [1:0] field;
   logic       inc, dec, commit, sw_run, sw_clear, ring;
   logic [5:0] led;

   int checks = 0;
   int failures = 0;
   int commit_cnt = 0;
   int clear_cnt = 0;
   int c0;

   clock_mode_controller #(.TIMEOUT_S(30), .RING_S(60)) dut (
      .clk(clk), .rst(rst), .btn(btn), .tick_1hz(tick_1hz),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
      .mode(mode), .fmt12(fmt12), .field(field), .inc(inc), .dec(dec),
      .commit(commit), .sw_run(sw_run), .sw_clear(sw_clear), .ring(ring),
      .led(led)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (commit === 1'b1) commit_cnt <= commit_cnt + 1;
      if (sw_clear === 1'b1) clear_cnt <= clear_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive a one-cycle pulse; on return the registered effect is visible.
   task automatic pulse(input logic [5:0] b);
      btn = b;
      cyc(1);
      btn = '0;
   endtask

   task automatic tick();
      tick_1hz = 1'b1;
      cyc(1);
      tick_1hz = 1'b0;
   endtask

   task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      cur_hour = h;
      cur_min  = m;
      cur_sec  = s;
   endtask

   initial begin
      rst = 1'b1;
      btn = '0;
      tick_1hz = 1'b0;
      set_time(5'd12, 6'd0, 6'd0);
      alarm_hour = 5'd7;
      alarm_min  = 6'd30;
      alarm_en   = 1'b0;
      cyc(3);

      // Reset state
      check("rst_mode", mode, 0);
      check("rst_fmt12", fmt12, 0);
      check("rst_field", field, 0);
      check("rst_strobes", {inc, dec, commit, sw_clear}, 0);
      check("rst_sw_run", sw_run, 0);
      check("rst_ring", ring, 0);
      check("rst_led", led, 6'b000001);
      rst = 1'b0;
      cyc(1);
      check("idle_mode", mode, 0);

      // DISP: SEL toggles 12h format
      pulse(B_SEL);
      check("fmt12_on", fmt12, 1);
      cyc(2);
      pulse(B_SEL);
      check("fmt12_off", fmt12, 0);
      cyc(2);

      // Test 1: edit sequence in TIME_SET
      pulse(B_MODE);
      check("t1_mode_ts", mode, 1);
      check("t1_led_ts", led, 6'b000010);
      check("t1_field0", field, 0);
      cyc(2);
      pulse(B_SEL);
      check("t1_field1", field, 1);
      cyc(2);
      pulse(B_SEL);
      check("t1_field2", field, 2);
      cyc(2);
      pulse(B_UP);
      check("t1_inc", {inc, dec, commit}, 3'b100);
      check("t1_inc_field", field, 2);
      cyc(1);
      check("t1_inc_one_cycle", inc, 0);
      cyc(1);
      pulse(B_UP | B_DN);
      check("t1_up_over_down", {inc, dec}, 2'b10);
      cyc(2);
      pulse(B_DN);
      check("t1_dec", {inc, dec}, 2'b01);
      cyc(2);
      c0 = commit_cnt;
      pulse(B_OK);
      check("t1_commit", commit, 1);
      check("t1_mode_disp", mode, 0);
      check("t1_field_clr", field, 0);
      cyc(1);
      check("t1_commit_one", commit, 0);
      check("t1_commit_count", commit_cnt - c0, 1);

      // Test 2: inactivity timeout
      c0 = commit_cnt;
      pulse(B_MODE);
      check("t2_enter", mode, 1);
      for (int i = 1; i <= 29; i++) begin
         tick();
         cyc(1);
      end
      check("t2_before_to", mode, 1);
      tick();
      check("t2_timeout", mode, 0);
      check("t2_to_field", field, 0);
      cyc(1);
      check("t2_no_commit", commit_cnt - c0, 0);

      pulse(B_MODE);
      for (int i = 1; i <= 28; i++) begin
         tick();
         cyc(1);
      end
      btn = B_SEL;
      tick();
      btn = '0;
      check("t2_sel_field", field, 1);
      cyc(1);
      tick();
      check("t2_sel_keeps", mode, 1);
      cyc(1);
      check("t2_no_commit2", commit_cnt - c0, 0);

      // Priority: OK over SEL
      pulse(B_SEL | B_OK);
      check("pri_ok_commit", commit, 1);
      check("pri_ok_mode", mode, 0);
      check("pri_ok_field", field, 0);
      cyc(2);

      // Walk to STOPWATCH
      pulse(B_MODE);
      pulse(B_MODE);
      check("walk_as", mode, 2);
      pulse(B_SEL);
      check("as_field1", field, 1);
      pulse(B_SEL);
      check("as_field_wrap", field, 0);
      pulse(B_MODE);
      check("walk_sw", mode, 3);

      // Test 3: stopwatch
      c0 = clear_cnt;
      pulse(B_UP);
      check("t3_run", sw_run, 1);
      cyc(1);
      pulse(B_DN);
      check("t3_no_clear", sw_clear, 0);
      cyc(1);
      check("t3_no_clear_cnt", clear_cnt - c0, 0);
      pulse(B_UP);
      check("t3_stop", sw_run, 0);
      cyc(1);
      pulse(B_DN);
      check("t3_clear", sw_clear, 1);
      cyc(1);
      check("t3_clear_one", sw_clear, 0);
      check("t3_clear_cnt", clear_cnt - c0, 1);
      pulse(B_UP);
      pulse(B_MODE);
      check("t3_mode_disp", mode, 0);
      check("t3_run_held", sw_run, 1);
      cyc(1);

      // Test 4: alarm in STOPWATCH, dismiss by OK
      pulse(B_MODE);
      pulse(B_MODE);
      pulse(B_MODE);
      check("t4_in_sw", mode, 3);
      alarm_en = 1'b1;
      set_time(5'd7, 6'd29, 6'd59);
      cyc(2);
      check("t4_led_en", led, 6'b101000);
      check("t4_no_ring_early", ring, 0);
      set_time(5'd7, 6'd30, 6'd0);
      cyc(1);
      check("t4_alarming", mode, 4);
      check("t4_ring", ring, 1);
      check("t4_led_alarm", led, 6'b110000);
      check("t4_sw_bg", sw_run, 1);
      cyc(2);
      c0 = commit_cnt;
      pulse(B_OK);
      check("t4_dismiss_ring", ring, 0);
      check("t4_dismiss_mode", mode, 3);
      cyc(1);
      check("t4_no_refire", mode, 3);
      check("t4_ok_consumed", commit_cnt - c0, 0);
      set_time(5'd7, 6'd30, 6'd1);

      // Test 5: match in ALARM_SET is dropped
      pulse(B_MODE);
      pulse(B_MODE);
      pulse(B_MODE);
      check("t5_in_as", mode, 2);
      set_time(5'd7, 6'd29, 6'd59);
      cyc(2);
      set_time(5'd7, 6'd30, 6'd0);
      cyc(1);
      check("t5_as_no_ring", ring, 0);
      check("t5_as_mode", mode, 2);
      cyc(2);
      pulse(B_MODE);
      check("t5_no_late_fire", mode, 3);
      pulse(B_MODE);
      check("t5_disp", mode, 0);
      set_time(5'd7, 6'd30, 6'd1);

      // Test 5b: ring timeout from DISP
      set_time(5'd7, 6'd29, 6'd59);
      cyc(2);
      set_time(5'd7, 6'd30, 6'd0);
      cyc(1);
      check("t5_ring_start", ring, 1);
      check("t5_alarming", mode, 4);
      for (int i = 1; i <= 59; i++) begin
         tick();
      end
      check("t5_ring_59", ring, 1);
      check("t5_mode_59", mode, 4);
      tick();
      check("t5_ring_end", ring, 0);
      check("t5_ret_disp", mode, 0);
      set_time(5'd7, 6'd30, 6'd1);
      cyc(1);

      // Test 6: MODE beats OK
      c0 = commit_cnt;
      pulse(B_MODE);
      pulse(B_MODE | B_OK);
      check("t6_mode_over_ok", mode, 2);
      cyc(1);
      check("t6_no_commit", commit_cnt - c0, 0);
      pulse(B_MODE);
      pulse(B_MODE);
      check("t6_disp", mode, 0);

      // Trigger beats a simultaneous button
      set_time(5'd7, 6'd29, 6'd59);
      cyc(2);
      set_time(5'd7, 6'd30, 6'd0);
      pulse(B_MODE);
      check("t6_trig_wins", mode, 4);
      check("t6_trig_ring", ring, 1);
      cyc(1);

      // alarm_en falling dismisses immediately
      alarm_en = 1'b0;
      cyc(1);
      check("fall_ring", ring, 0);
      check("fall_mode", mode, 0);
      check("fall_led", led, 6'b000001);

      // Reset while ringing
      alarm_en = 1'b1;
      set_time(5'd7, 6'd29, 6'd59);
      cyc(2);
      set_time(5'd7, 6'd30, 6'd0);
      cyc(1);
      check("rr_alarming", mode, 4);
      rst = 1'b1;
      cyc(1);
      check("rr_ring", ring, 0);
      check("rr_mode", mode, 0);
      check("rr_sw_run", sw_run, 0);
      rst = 1'b0;
      cyc(2);
      check("rr_no_spurious", mode, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Central sequencer for the digital-clock top level. It sits between the six debounced button pulses and the time counter, the stopwatch, the display controller and the buzzer/light controllers.
- Owns the mode FSM (display, time set, alarm set, stopwatch, alarming), the edit-field selection, the inactivity timeout and alarm triggering.
- Emits one-cycle command strobes to the datapath and a registered mode for output muxing.

Parameters:
TIMEOUT_S, 30, seconds of no button activity in a SET mode before abandoning the edit
RING_S, 60, seconds the alarm rings before auto-dismiss

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
btn  in  6  debounced single-cycle pulses: [0]MODE [1]SEL [2]UP/START [3]DOWN/CLEAR [4]OK [5]unused
tick_1hz  in  1  one-cycle strobe per second from time counter
cur_hour  in  5  current hour 0-23
cur_min  in  6  current minute 0-59
cur_sec  in  6  current second 0-59
alarm_hour  in  5  stored alarm hour
alarm_min  in  6  stored alarm minute
alarm_en  in  1  alarm armed
mode  out  3  0 DISP, 1 TIME_SET, 2 ALARM_SET, 3 STOPWATCH, 4 ALARMING
fmt12  out  1  display 12-hour format
field  out  2  edited field: 0 hour, 1 min, 2 sec
inc  out  1  one-cycle increment-field strobe
dec  out  1  one-cycle decrement-field strobe
commit  out  1  one-cycle strobe: load edited value (time or alarm, per mode)
sw_run  out  1  stopwatch running level
sw_clear  out  1  one-cycle stopwatch clear strobe
ring  out  1  buzzer enable
led  out  6  one-hot of mode (bit = mode index), bit5 = alarm_en

Behaviour:
- All outputs are registered. A button pulse in cycle N takes effect (state change or strobe) in cycle N+1.
- Reset values:
  - mode=DISP; fmt12=0; field=0.
  - inc, dec, commit, sw_clear = 0; sw_run=0; ring=0.
  - Timeout counter and ring counter = 0.
  - match_d=1, which suppresses a spurious trigger right after reset.
- Button priority when several pulse in the same cycle: MODE > OK > SEL > UP > DOWN. Only the highest is acted on; the rest are dropped.
- DISP:
  - MODE -> TIME_SET, field=0.
  - SEL toggles fmt12.
  - Other buttons are ignored.
- TIME_SET:
  - SEL: field 0->1->2->0.
  - UP pulses inc; DOWN pulses dec.
  - OK pulses commit, then -> DISP, field=0.
  - MODE -> ALARM_SET, field=0, no commit (edit discarded).
- ALARM_SET:
  - Same as TIME_SET, except field cycles 0->1->0.
  - MODE -> STOPWATCH, no commit.
- STOPWATCH:
  - UP toggles sw_run.
  - DOWN pulses sw_clear only when sw_run=0; ignored while running.
  - MODE -> DISP. sw_run keeps its value in every mode, so the stopwatch runs in background.
- Inactivity timeout (TIME_SET/ALARM_SET only):
  - The counter clears on any btn pulse and on mode entry.
  - It increments on tick_1hz.
  - Reaching TIMEOUT_S -> DISP, field=0, no commit.
- Alarm trigger:
  - match = alarm_en & cur_hour==alarm_hour & cur_min==alarm_min & cur_sec==0.
  - match_d is match registered each cycle. The trigger fires on match & ~match_d.
  - The trigger is honoured only in DISP or STOPWATCH. In the SET modes it is dropped and does not re-fire that minute.
  - On trigger: save the current mode into ret_mode, enter ALARMING, set ring=1, clear the ring counter.
- ALARMING:
  - Any btn pulse -> ring=0, return to ret_mode. The button is consumed and has no other effect.
  - The ring counter increments on tick_1hz. Reaching RING_S -> ring=0, return to ret_mode.
  - alarm_en falling -> immediate dismiss, same as a button.
- Trigger vs button in the same cycle: the trigger wins and the button is dropped.
- Reset mid-ALARMING: ring drops the next cycle and mode=DISP.
- inc, dec, commit and sw_clear are never asserted in the same cycle as each other.

Test Plan:
1. Reset, then MODE, SEL, SEL, UP, OK at 3-cycle spacing -> mode 0->1, field 0->1->2, one inc with field=2, one commit, then mode=0 and field=0.
2. In TIME_SET, no buttons, 30 tick_1hz strobes -> mode=0 after the 30th tick and commit never asserted. Repeat with a SEL at tick 29 -> still TIME_SET at tick 30.
3. STOPWATCH: UP -> sw_run=1; DOWN -> no sw_clear; UP -> sw_run=0; DOWN -> sw_clear for exactly one cycle. MODE -> mode=0 with sw_run held.
4. alarm_en=1 at 07:30, cur stepping 07:29:59 -> 07:30:00 while in STOPWATCH -> mode=4 and ring=1 one cycle later. btn[4] -> ring=0 and mode=3.
5. Alarm match while in ALARM_SET -> no ring. Alarm match in DISP with no buttons -> ring for 60 ticks, then mode=0 and ring=0.
6. MODE and OK pulsed in the same cycle in TIME_SET -> mode=2 and no commit. Trigger and btn in the same cycle in DISP -> mode=4.
